// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the load/store bus bridge.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS   = 2'b01,
    FIN   = 2'b10,
    FAULT = 2'b11
  } state_t;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] be_gen(input size_t sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-justified store data across every lane it may land in.
  function automatic logic [31:0] wdata_rep(input size_t sz, input logic [31:0] data);
    logic [31:0] wd;
    case (sz)
      SIZE_BYTE: wd = {4{data[7:0]}};
      SIZE_HALF: wd = {2{data[15:0]}};
      default:   wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_bridge_load_align.sv
// Lane select and sign/zero extension of bus read data.
module load_align
  import mem_bridge_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: result = {{24{~uns & byte_sel[7]}}, byte_sel};
      SIZE_HALF: result = {{16{~uns & half_sel[15]}}, half_sel};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Bridge from CPU load/store control to a word-wide req/ack memory bus.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       data,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [31:0]       out,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  // First byte address past the bus window; 64 bits so ADDR_W=30 needs no special case.
  localparam logic [63:0] ADDR_LIM = 64'h1 << (ADDR_W + 2);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [1:0]        off_q, off_d;
  size_t             size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       out_q, out_d;

  size_t       size_in;
  logic        access;
  logic        fault_req;
  logic        timed_out;
  logic [31:0] load_res;

  // Classify the incoming request; only meaningful while idle.
  always_comb begin
    size_in   = size_t'(size);
    access    = rd | we;
    fault_req = (rd & we)
              | (size_in == SIZE_ILL)
              | ((size_in == SIZE_HALF) & addr[0])
              | ((size_in == SIZE_WORD) & (addr[1:0] != 2'b00))
              | ({32'h0, addr} >= ADDR_LIM);
    timed_out = (cnt_q == TO_VAL);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ack wins over timeout on the final cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (access) state_d = fault_req ? FAULT : BUS;
      BUS: begin
        if (mem_ack)        state_d = FIN;
        else if (timed_out) state_d = FAULT;
      end
      FIN:   state_d = IDLE;
      FAULT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; mem_req drops as soon as reset asserts.
  always_comb begin
    mem_req = (state_q == BUS);
    done    = (state_q == FIN) || (state_q == FAULT);
    error   = (state_q == FAULT);
  end

  // Request latching, timeout counting and load capture.
  always_comb begin
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    out_d       = out_q;
    if ((state_q == IDLE) && access && !fault_req) begin
      cnt_d       = '0;
      mem_we_d    = we;
      mem_addr_d  = addr[ADDR_W+1:2];
      mem_wdata_d = wdata_rep(size_in, data);
      mem_be_d    = be_gen(size_in, addr[1:0]);
      off_d       = addr[1:0];
      size_d      = size_in;
      uns_d       = uns;
    end
    if (state_q == BUS) begin
      if (mem_ack) begin
        if (!mem_we_q) out_d = load_res;
      end else if (!timed_out) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      off_q       <= '0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      out_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      out_q       <= out_d;
    end
  end

  load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (load_res)
  );

  assign out       = out_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge; a second instance narrows the bus window.
module tb_mem_bridge;

  logic        clk, rst;
  logic        rd, we, uns, mem_ack;
  logic [31:0] addr, data, mem_rdata;
  logic [1:0]  size;

  logic [31:0] out, mem_wdata;
  logic        done, error, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  logic [31:0] b_out, b_mem_wdata;
  logic        b_done, b_error, b_mem_req, b_mem_we;
  logic [27:0] b_mem_addr;
  logic [3:0]  b_mem_be;

  int total = 0;
  int bad   = 0;

  mem_bridge dut (
    .clk(clk), .rst(rst), .rd(rd), .we(we), .addr(addr), .data(data),
    .size(size), .uns(uns), .out(out), .done(done), .error(error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  mem_bridge #(.ADDR_W(28), .TIMEOUT(15)) dut_b (
    .clk(clk), .rst(rst), .rd(rd), .we(we), .addr(addr), .data(data),
    .size(size), .uns(uns), .out(b_out), .done(b_done), .error(b_error),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] d, input logic u);
    rd = r; we = w; addr = a; size = sz; data = d; uns = u;
  endtask

  task automatic quiet();
    rd = 1'b0; we = 1'b0;
  endtask

  // Full bus transaction with ack after wait_cyc extra cycles of mem_req.
  task automatic xfer(input string tag, input logic r, input logic w,
                      input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] d, input logic u,
                      input logic [31:0] rdat, input int wait_cyc,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_out);
    issue(r, w, a, sz, d, u);
    step();
    quiet();
    chk({tag, ".req"},   mem_req, 1);
    chk({tag, ".addr"},  mem_addr, a >> 2);
    chk({tag, ".be"},    mem_be, exp_be);
    chk({tag, ".we"},    mem_we, w);
    chk({tag, ".wdata"}, mem_wdata, exp_wd);
    for (int i = 0; i < wait_cyc; i++) begin
      step();
      chk({tag, ".req_hold"}, mem_req, 1);
      chk({tag, ".early_done"}, done, 0);
    end
    mem_ack = 1'b1;
    mem_rdata = rdat;
    step();
    mem_ack = 1'b0;
    chk({tag, ".done"},  done, 1);
    chk({tag, ".err"},   error, 0);
    chk({tag, ".req_off"}, mem_req, 0);
    chk({tag, ".out"},   out, exp_out);
    step();
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  // Request rejected in IDLE: done/error next cycle, no bus request.
  task automatic fault(input string tag, input logic r, input logic w,
                       input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] exp_out);
    issue(r, w, a, sz, 32'h0, 1'b0);
    step();
    quiet();
    chk({tag, ".req"},  mem_req, 0);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".err"},  error, 1);
    chk({tag, ".out"},  out, exp_out);
    chk({tag, ".b_err"}, b_error, 1);
    step();
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".err_pulse"}, error, 0);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; we = 1'b0; addr = '0; data = '0; size = '0;
    uns = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    step();
    step();
    chk("rst.out", out, 0);
    chk("rst.done", done, 0);
    chk("rst.err", error, 0);
    chk("rst.req", mem_req, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.be", mem_be, 0);
    rst = 1'b0;
    step();

    xfer("st_word",  1'b0, 1'b1, 32'h100, 2'b10, 32'hDEADBEEF, 1'b0,
         32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
    xfer("ld_byte_s", 1'b1, 1'b0, 32'h103, 2'b00, 32'h0, 1'b0,
         32'h80123456, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
    xfer("ld_byte_u", 1'b1, 1'b0, 32'h103, 2'b00, 32'h0, 1'b1,
         32'h80123456, 0, 4'b1000, 32'h0, 32'h00000080);
    xfer("ld_half_s", 1'b1, 1'b0, 32'h102, 2'b01, 32'h0, 1'b0,
         32'h80011234, 2, 4'b1100, 32'h0, 32'hFFFF8001);
    xfer("ld_byte1_u", 1'b1, 1'b0, 32'h101, 2'b00, 32'h0, 1'b1,
         32'h0000F100, 0, 4'b0010, 32'h0, 32'h000000F1);
    xfer("st_half",  1'b0, 1'b1, 32'h102, 2'b01, 32'h0000ABCD, 1'b0,
         32'h0, 5, 4'b1100, 32'hABCDABCD, 32'h000000F1);

    fault("f_misalign", 1'b1, 1'b0, 32'h101, 2'b10, 32'h000000F1);
    fault("f_size",     1'b1, 1'b0, 32'h100, 2'b11, 32'h000000F1);
    fault("f_rdwe",     1'b1, 1'b1, 32'h100, 2'b10, 32'h000000F1);
    fault("f_half_odd", 1'b0, 1'b1, 32'h103, 2'b01, 32'h000000F1);

    // Out-of-range only for the 28-bit instance; the default one runs the bus.
    issue(1'b1, 1'b0, 32'hF0000000, 2'b10, 32'h0, 1'b0);
    step();
    quiet();
    chk("oor.b_req",  b_mem_req, 0);
    chk("oor.b_done", b_done, 1);
    chk("oor.b_err",  b_error, 1);
    chk("oor.b_out",  b_out, 32'h000000F1);
    chk("oor.a_req",  mem_req, 1);
    chk("oor.a_addr", mem_addr, 32'h3C000000);
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    chk("oor.a_done", done, 1);
    chk("oor.a_err",  error, 0);
    chk("oor.a_out",  out, 32'h12345678);
    chk("oor.b_done_pulse", b_done, 0);
    step();

    // Timeout: mem_req for 16 cycles, fault on the 17th.
    issue(1'b1, 1'b0, 32'h200, 2'b10, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) quiet();
      chk("to.req", mem_req, 1);
      chk("to.done_early", done, 0);
    end
    step();
    chk("to.req_off", mem_req, 0);
    chk("to.done", done, 1);
    chk("to.err",  error, 1);
    chk("to.out",  out, 32'h12345678);
    chk("to.b_err", b_error, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step();
    chk("late.done", done, 0);
    chk("late.req",  mem_req, 0);
    step();
    mem_ack = 1'b0;
    chk("late.done2", done, 0);
    chk("late.out", out, 32'h12345678);
    step();

    // Reset in the middle of a bus access.
    issue(1'b1, 1'b0, 32'h300, 2'b10, 32'h0, 1'b0);
    step();
    quiet();
    chk("rbus.req", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rbus.req_drop", mem_req, 0);
    chk("rbus.done", done, 0);
    step();
    rst = 1'b0;
    chk("rbus.out", out, 0);
    step();
    chk("rbus.done_after", done, 0);
    chk("rbus.req_after", mem_req, 0);
    xfer("post_rst", 1'b1, 1'b0, 32'h10, 2'b10, 32'h0, 1'b0,
         32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
